// File: rtl/sprite_descriptor_writer.sv
// Sprite descriptor writer.
// Game logic posts sprite updates through a valid/ready handshake. Each update
// is clamped to the screen and packed into a shadow bank. On frame_sync the
// shadow bank is copied into the active bank, one slot per cycle, so the
// renderer only ever sees whole frames. The active descriptor of rd_id is
// presented on a registered 64-bit bus.
module sprite_descriptor_writer #(
    parameter int NUM_SPRITES = 4,
    parameter int ID_W        = 2,
    parameter int SCREEN_W    = 640,
    parameter int SCREEN_H    = 480
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   upd_valid,
    output logic                   upd_ready,
    input  logic [ID_W-1:0]        upd_id,
    input  logic [15:0]            upd_x,
    input  logic [15:0]            upd_y,
    input  logic [15:0]            upd_w,
    input  logic [15:0]            upd_h,
    input  logic                   frame_sync,
    input  logic [ID_W-1:0]        rd_id,
    output logic [63:0]            sprite_data,
    output logic [NUM_SPRITES-1:0] pending,
    output logic                   commit_done
);

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        COMMIT = 1'b1
    } state_t;

    localparam logic [ID_W-1:0] LAST_ID  = ID_W'(NUM_SPRITES - 1);
    localparam logic [15:0]     SCR_W_16 = 16'(SCREEN_W);
    localparam logic [15:0]     SCR_H_16 = 16'(SCREEN_H);

    // Clamp an update so that X+W and Y+H never exceed the screen, then pack
    // it as {X, Y, W, H}. Width and height are clamped first so the
    // remaining room for the origin can never go negative.
    function automatic logic [63:0] pack_descriptor(
        input logic [15:0] x,
        input logic [15:0] y,
        input logic [15:0] w,
        input logic [15:0] h
    );
        logic [15:0] w_c;
        logic [15:0] h_c;
        logic [15:0] x_lim;
        logic [15:0] y_lim;
        logic [15:0] x_c;
        logic [15:0] y_c;
        w_c   = (w > SCR_W_16) ? SCR_W_16 : w;
        h_c   = (h > SCR_H_16) ? SCR_H_16 : h;
        x_lim = SCR_W_16 - w_c;
        y_lim = SCR_H_16 - h_c;
        x_c   = (x > x_lim) ? x_lim : x;
        y_c   = (y > y_lim) ? y_lim : y;
        return {x_c, y_c, w_c, h_c};
    endfunction

    state_t                 state_r;
    logic [ID_W-1:0]        cnt_r;
    logic [63:0]            shadow_r [NUM_SPRITES];
    logic [63:0]            active_r [NUM_SPRITES];
    logic [NUM_SPRITES-1:0] pending_r;
    logic                   commit_done_r;
    logic                   upd_ready_r;
    logic [63:0]            sprite_data_r;

    logic                   handshake_s;
    logic [63:0]            new_desc_s;
    logic [63:0]            read_data_s;

    // Handshake qualification, clamp/pack of the incoming update, and the
    // readout source: the slot being copied this cycle is forwarded from the
    // shadow bank so the bus shows the post-copy value right after the edge.
    always_comb begin
        handshake_s = upd_valid & upd_ready_r;
        new_desc_s  = pack_descriptor(upd_x, upd_y, upd_w, upd_h);
        if ((state_r == COMMIT) && (cnt_r == rd_id)) begin
            read_data_s = shadow_r[cnt_r];
        end else begin
            read_data_s = active_r[rd_id];
        end
    end

    // Update/commit state machine, both descriptor banks and all registered outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r       <= IDLE;
            cnt_r         <= '0;
            pending_r     <= '0;
            commit_done_r <= 1'b0;
            upd_ready_r   <= 1'b0;
            sprite_data_r <= 64'h0;
            for (int i = 0; i < NUM_SPRITES; i++) begin
                shadow_r[i] <= 64'h0;
                active_r[i] <= 64'h0;
            end
        end else begin
            commit_done_r <= 1'b0;
            sprite_data_r <= read_data_s;
            case (state_r)
                IDLE: begin
                    if (handshake_s) begin
                        shadow_r[upd_id]  <= new_desc_s;
                        pending_r[upd_id] <= 1'b1;
                    end else begin
                        pending_r <= pending_r;
                    end
                    if (frame_sync) begin
                        state_r     <= COMMIT;
                        cnt_r       <= '0;
                        upd_ready_r <= 1'b0;
                    end else begin
                        upd_ready_r <= 1'b1;
                    end
                end
                COMMIT: begin
                    active_r[cnt_r]  <= shadow_r[cnt_r];
                    pending_r[cnt_r] <= 1'b0;
                    cnt_r            <= cnt_r + ID_W'(1);
                    if (cnt_r == LAST_ID) begin
                        state_r       <= IDLE;
                        commit_done_r <= 1'b1;
                        upd_ready_r   <= 1'b1;
                    end else begin
                        upd_ready_r   <= 1'b0;
                    end
                end
                default: begin
                    state_r     <= IDLE;
                    cnt_r       <= '0;
                    upd_ready_r <= 1'b0;
                end
            endcase
        end
    end

    assign upd_ready   = upd_ready_r;
    assign sprite_data = sprite_data_r;
    assign pending     = pending_r;
    assign commit_done = commit_done_r;

endmodule

// File: tb/tb_sprite_descriptor_writer.sv
// Self-checking bench for sprite_descriptor_writer: directed scenarios with
// hand-computed descriptors, then randomized traffic, all compared every cycle
// against a transaction-level model of the shadow/active banks.
module tb_sprite_descriptor_writer;

    localparam int N   = 4;
    localparam int SW  = 640;
    localparam int SH  = 480;

    logic        clock = 1'b0;
    logic        reset;
    logic        upd_valid;
    logic        upd_ready;
    logic [1:0]  upd_id;
    logic [15:0] upd_x;
    logic [15:0] upd_y;
    logic [15:0] upd_w;
    logic [15:0] upd_h;
    logic        frame_sync;
    logic [1:0]  rd_id;
    logic [63:0] sprite_data;
    logic [3:0]  pending;
    logic        commit_done;

    int checks = 0;
    int errors = 0;

    sprite_descriptor_writer #(
        .NUM_SPRITES(N), .ID_W(2), .SCREEN_W(SW), .SCREEN_H(SH)
    ) dut (
        .clock(clock), .reset(reset),
        .upd_valid(upd_valid), .upd_ready(upd_ready), .upd_id(upd_id),
        .upd_x(upd_x), .upd_y(upd_y), .upd_w(upd_w), .upd_h(upd_h),
        .frame_sync(frame_sync), .rd_id(rd_id),
        .sprite_data(sprite_data), .pending(pending), .commit_done(commit_done)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Reference clamp: plain integer min() arithmetic.
    function automatic logic [63:0] ref_desc(input int x, input int y, input int w, input int h);
        int wc, hc, xc, yc;
        wc = (w < SW) ? w : SW;
        hc = (h < SH) ? h : SH;
        xc = (x < SW - wc) ? x : SW - wc;
        yc = (y < SH - hc) ? y : SH - hc;
        return {16'(xc), 16'(yc), 16'(wc), 16'(hc)};
    endfunction

    // Behavioural model: banks as arrays, commit as a copy counter.
    logic [63:0] m_shadow [N];
    logic [63:0] m_active [N];
    logic [3:0]  m_pending;
    logic        m_ready;
    logic        m_done;
    logic [63:0] m_sd;
    bit          m_busy;
    int          m_idx;
    bit          m_live = 1'b0;

    always @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < N; i++) begin
                m_shadow[i] = 64'h0;
                m_active[i] = 64'h0;
            end
            m_pending = 4'h0;
            m_ready   = 1'b0;
            m_done    = 1'b0;
            m_busy    = 1'b0;
            m_idx     = 0;
        end else begin
            m_done = 1'b0;
            if (!m_busy) begin
                if (upd_valid && m_ready) begin
                    m_shadow[upd_id]  = ref_desc(int'(upd_x), int'(upd_y), int'(upd_w), int'(upd_h));
                    m_pending[upd_id] = 1'b1;
                end
                if (frame_sync) begin
                    m_busy = 1'b1;
                    m_idx  = 0;
                end
            end else begin
                m_active[m_idx]  = m_shadow[m_idx];
                m_pending[m_idx] = 1'b0;
                m_idx++;
                if (m_idx == N) begin
                    m_busy = 1'b0;
                    m_done = 1'b1;
                end
            end
            m_ready = !m_busy;
        end
        m_sd   = m_active[rd_id];
        m_live = 1'b1;
    end

    // Every-cycle comparison of all outputs against the model.
    always @(negedge clock) begin
        if (m_live) begin
            check("upd_ready", {63'h0, upd_ready}, {63'h0, m_ready});
            check("pending", {60'h0, pending}, {60'h0, m_pending});
            check("commit_done", {63'h0, commit_done}, {63'h0, m_done});
            check("sprite_data", sprite_data, m_sd);
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic post(input logic [1:0] id, input int x, input int y, input int w, input int h);
        logic acc;
        acc       = 1'b0;
        upd_id    = id;
        upd_x     = 16'(x);
        upd_y     = 16'(y);
        upd_w     = 16'(w);
        upd_h     = 16'(h);
        upd_valid = 1'b1;
        for (int k = 0; k < 20; k++) begin
            acc = upd_ready;
            @(negedge clock);
            if (acc) break;
        end
        upd_valid = 1'b0;
        check("post_accepted", {63'h0, acc}, 64'h1);
    endtask

    // Returns the number of negedges until commit_done is seen (0 = never).
    task automatic wait_done(output int k);
        k = 0;
        for (int i = 1; i <= 12; i++) begin
            @(negedge clock);
            frame_sync = 1'b0;
            if (commit_done) begin
                k = i;
                break;
            end
        end
    endtask

    task automatic read_slot(input logic [1:0] id, input logic [63:0] exp, input string name);
        rd_id = id;
        @(negedge clock);
        check(name, sprite_data, exp);
    endtask

    initial begin
        int k;
        int pulses;
        reset = 1'b1; upd_valid = 1'b0; upd_id = 2'd0; upd_x = 16'd0; upd_y = 16'd0;
        upd_w = 16'd0; upd_h = 16'd0; frame_sync = 1'b0; rd_id = 2'd0;
        cyc(3);
        reset = 1'b0;
        cyc(1);
        check("ready_after_reset", {63'h0, upd_ready}, 64'h1);
        check("pending_after_reset", {60'h0, pending}, 64'h0);
        for (int i = 0; i < N; i++) read_slot(2'(i), 64'h0, "reset_slot");

        // Basic update and commit
        post(2'd1, 100, 50, 32, 64);
        check("basic_pending", {60'h0, pending}, 64'h2);
        read_slot(2'd1, 64'h0, "basic_before_commit");
        frame_sync = 1'b1;
        wait_done(k);
        check("basic_latency", 64'(k), 64'd5);
        check("basic_slot1", sprite_data, 64'h0064_0032_0020_0040);
        check("basic_pending_clear", {60'h0, pending}, 64'h0);

        // Clamping
        post(2'd0, 630, 470, 32, 32);
        post(2'd2, 5, 0, 1000, 10);
        frame_sync = 1'b1;
        wait_done(k);
        check("clamp_latency", 64'(k), 64'd5);
        read_slot(2'd0, 64'h0260_01C0_0020_0020, "clamp_slot0");
        read_slot(2'd2, 64'h0000_0000_0280_000A, "clamp_slot2");

        // Update in the same cycle as frame_sync
        upd_id = 2'd3; upd_x = 16'd7; upd_y = 16'd9; upd_w = 16'd3; upd_h = 16'd4;
        upd_valid = 1'b1; frame_sync = 1'b1;
        cyc(1);
        upd_valid = 1'b0; frame_sync = 1'b0;
        wait_done(k);
        check("simul_latency", 64'(k), 64'd4);
        read_slot(2'd3, 64'h0007_0009_0003_0004, "simul_slot3");

        // Update held across a commit
        frame_sync = 1'b1;
        cyc(1);
        frame_sync = 1'b0;
        upd_id = 2'd2; upd_x = 16'd1; upd_y = 16'd2; upd_w = 16'd3; upd_h = 16'd4;
        upd_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check("held_ready_low", {63'h0, upd_ready}, 64'h0);
            cyc(1);
        end
        check("held_ready_back", {63'h0, upd_ready}, 64'h1);
        check("held_done", {63'h0, commit_done}, 64'h1);
        cyc(1);
        upd_valid = 1'b0;
        check("held_pending", {60'h0, pending}, 64'h4);

        // Double write, extra frame_sync during the commit
        post(2'd0, 10, 0, 8, 8);
        post(2'd0, 20, 0, 8, 8);
        frame_sync = 1'b1;
        cyc(1);
        frame_sync = 1'b0;
        pulses = 0;
        for (int i = 0; i < 12; i++) begin
            if (i == 1) frame_sync = 1'b1;
            if (i == 2) frame_sync = 1'b0;
            if (commit_done) pulses++;
            cyc(1);
        end
        check("single_commit_pulse", 64'(pulses), 64'd1);
        read_slot(2'd0, 64'h0014_0000_0008_0008, "double_write_slot0");

        // Reset on the second commit cycle
        post(2'd1, 300, 200, 16, 16);
        frame_sync = 1'b1;
        cyc(1);
        frame_sync = 1'b0;
        cyc(1);
        reset = 1'b1;
        cyc(1);
        reset = 1'b0;
        check("abort_ready_low", {63'h0, upd_ready}, 64'h0);
        cyc(1);
        check("abort_ready_high", {63'h0, upd_ready}, 64'h1);
        check("abort_pending", {60'h0, pending}, 64'h0);
        pulses = 0;
        for (int i = 0; i < N; i++) begin
            rd_id = 2'(i);
            cyc(1);
            if (commit_done) pulses++;
            check("abort_slot", sprite_data, 64'h0);
        end
        check("abort_no_done", 64'(pulses), 64'd0);

        // Randomized traffic
        for (int i = 0; i < 1500; i++) begin
            reset      = ($urandom_range(0, 199) == 0);
            upd_valid  = $urandom_range(0, 1) == 1;
            upd_id     = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 3) == 0) begin
                upd_x = 16'($urandom); upd_y = 16'($urandom);
                upd_w = 16'($urandom); upd_h = 16'($urandom);
            end else begin
                upd_x = 16'($urandom_range(0, 700)); upd_y = 16'($urandom_range(0, 520));
                upd_w = 16'($urandom_range(0, 700)); upd_h = 16'($urandom_range(0, 520));
            end
            frame_sync = ($urandom_range(0, 15) == 0);
            rd_id      = 2'($urandom_range(0, 3));
            cyc(1);
        end
        reset = 1'b0; upd_valid = 1'b0; frame_sync = 1'b0;
        cyc(8);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sprite_descriptor_writer.md
Name: sprite_descriptor_writer

Overview:
- Producer side of the 64-bit sprite descriptor bus that the per-pixel sprite hit test consumes.
- Game logic posts sprite position and size updates through a valid/ready handshake. The block clamps each update to the screen and packs it into a shadow bank.
- At each frame boundary it copies the shadow bank into the active bank, so the renderer never sees a half-updated frame.
- Sits between the physics/game-state logic and the VGA pixel pipeline.

Parameters:
- NUM_SPRITES, 4, number of descriptor slots (power of 2, min 2).
- ID_W, 2, log2(NUM_SPRITES).
- SCREEN_W, 640, screen width in pixels.
- SCREEN_H, 480, screen height in pixels.

Ports:
- clock  in  1  single system clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high reset.
- upd_valid  in  1  update request present.
- upd_ready  out  1  block can accept an update this cycle.
- upd_id  in  ID_W  target slot.
- upd_x  in  16  bottom-left X, y-up screen coordinates.
- upd_y  in  16  bottom-left Y, y-up screen coordinates.
- upd_w  in  16  sprite width.
- upd_h  in  16  sprite height.
- frame_sync  in  1  one-cycle pulse at start of vertical blank.
- rd_id  in  ID_W  slot selected for readout.
- sprite_data  out  64  active descriptor of rd_id: [63:48]=X, [47:32]=Y, [31:16]=W, [15:0]=H.
- pending  out  NUM_SPRITES  bit i set = shadow slot i differs from active (written, not yet committed).
- commit_done  out  1  one-cycle pulse when a commit finishes.

Behaviour:
- Clock and reset: one clock (clock); reset is synchronous and active-high (reset).
- Reset values:
  - All shadow and active slots = 0.
  - sprite_data = 0, pending = 0, commit_done = 0.
  - upd_ready = 0 during the reset cycle, 1 from the first cycle after reset deasserts.
  - State = IDLE.
- State machine:
  - IDLE: upd_ready = 1. A handshake (upd_valid & upd_ready) writes the clamped, packed descriptor into shadow[upd_id] at the clock edge and sets pending[upd_id]. frame_sync moves to COMMIT, with cnt = 0.
  - COMMIT: upd_ready = 0. Each cycle: active[cnt] <= shadow[cnt], pending[cnt] cleared, cnt++. After the copy of slot NUM_SPRITES-1, commit_done pulses for exactly one cycle and the state returns to IDLE. A commit takes exactly NUM_SPRITES cycles.
- Clamping (combinational on the inputs, applied before the shadow write; all 16-bit unsigned):
  - W' = min(upd_w, SCREEN_W); H' = min(upd_h, SCREEN_H).
  - X' = min(upd_x, SCREEN_W - W'); Y' = min(upd_y, SCREEN_H - H').
  - Result: X'+W' <= SCREEN_W and Y'+H' <= SCREEN_H always, so the consumer's sums never overflow.
  - W' = 0 or H' = 0 is legal and means the sprite is hidden (no pixel passes the consumer's strict compare).
- Readout: sprite_data is registered, 1-cycle latency from rd_id. It always reflects the active bank, never the shadow bank. During COMMIT a slot shows its new value from the cycle after it is copied.
- Boundary conditions:
  - Two updates to the same slot before a commit: the last one wins, and pending stays set.
  - Update and frame_sync in the same IDLE cycle: the update is accepted and is included in the commit that starts next cycle.
  - frame_sync during COMMIT: ignored, with no queued second commit.
  - upd_valid held during COMMIT: not accepted; the requester holds its inputs (standard valid/ready). It is accepted on the first IDLE cycle.
  - frame_sync with pending = 0: the commit still runs NUM_SPRITES cycles and commit_done still pulses.
  - Reset during COMMIT: aborts the commit; every state, bank and output goes to its reset value on that edge.

Test Plan:
- Reset release: after reset, upd_ready=1, pending=0; sprite_data=0 for every rd_id.
- Basic update and commit: update id=1, x=100, y=50, w=32, h=64. Before frame_sync, rd_id=1 reads 0 and pending=4'b0010. frame_sync, then after 4 cycles commit_done pulses and rd_id=1 reads 64'h0064_0032_0020_0040, with pending=0.
- Clamping:
  - id=0, x=630, y=470, w=32, h=32: commits as X=608, Y=448, W=32, H=32.
  - id=2, w=1000, h=10, x=5, y=0: commits as W=640, X=0, H=10, Y=0.
- Simultaneous events: update id=3 in the same cycle as frame_sync is included in that commit. upd_valid held during COMMIT: upd_ready stays 0 for 4 cycles, and the update is accepted on the next cycle with pending[id] set.
- Double write and ignored sync: two updates to id=0 (x=10, then x=20) commit X=20. A second frame_sync during COMMIT yields only one commit_done pulse.
- Reset mid-commit: assert reset on the 2nd COMMIT cycle. All slots read 0 afterwards, pending=0, no commit_done, and upd_ready=1 on the cycle after reset deasserts.
